// File: rtl/gba_bus_pkg.sv
// rtl/gba_bus_pkg.sv - shared bus encodings, address-mode and DMA state types
//
// Purpose: definitions shared by the CPU memory bus initiators and responders.
//   MEM_SIZE_*  : bus size encodings driven on the size port
//   addr_mode_t : per-transfer address step mode (mode value 3 behaves as FIXED)
//   dma_state_t : dma_bus_master sequencing states
//   dma_align   : forces an address onto a halfword or word boundary
package gba_bus_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;
  localparam logic [1:0] MEM_SIZE_RESR = 2'd3;

  typedef enum logic [1:0] {
    ADDR_INC   = 2'd0,
    ADDR_DEC   = 2'd1,
    ADDR_FIXED = 2'd2
  } addr_mode_t;

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_READ  = 2'd1,
    DMA_WRITE = 2'd2,
    DMA_DRAIN = 2'd3
  } dma_state_t;

  // Low address bits are cleared so every unit sits on its natural boundary.
  function automatic logic [31:0] dma_align(input logic [31:0] a, input logic half);
    return half ? {a[31:1], 1'b0} : {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dma_addr_step.sv
// rtl/dma_addr_step.sv - combinational next-address calculation for one DMA pointer
//
// Purpose: advances a source or destination pointer by one unit.
// Ports:
//   addr_i [31:0] : current pointer
//   mode_i [1:0]  : ADDR_INC / ADDR_DEC / ADDR_FIXED (3 behaves as FIXED)
//   half_i        : 1 = halfword units (stride 2), 0 = word units (stride 4)
//   addr_o [31:0] : pointer for the next unit, modulo 2^32
module dma_addr_step
  import gba_bus_pkg::*;
(
  input  logic [31:0] addr_i,
  input  logic [1:0]  mode_i,
  input  logic        half_i,
  output logic [31:0] addr_o
);

  logic [31:0] stride;

  always_comb begin
    stride = half_i ? 32'd2 : 32'd4;
    case (mode_i)
      ADDR_INC: addr_o = addr_i + stride;
      ADDR_DEC: addr_o = addr_i - stride;
      default:  addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/dma_bus_master.sv
// rtl/dma_bus_master.sv - single-channel bus initiator copying halfword/word blocks
//
// Purpose: copies cfg_cnt units (0 means 2^CNT_W) from a source region to a
//   destination region with alternating read and write address phases.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   start                          : request, accepted in IDLE when pause=0
//   cfg_src, cfg_dst               : start addresses, aligned on accept
//   cfg_cnt [CNT_W-1:0]            : unit count
//   cfg_half                       : 1 = halfword units, 0 = word units
//   cfg_src_mode, cfg_dst_mode     : INC=0, DEC=1, FIXED=2 (3 = FIXED)
//   addr, wdata, size, write       : bus address phase / write data (registered)
//   rdata                          : bus read data, the cycle after a read address
//   pause, abort                   : responder stall / responder error
//   busy, done, err                : status; done and err are one-cycle pulses
module dma_bus_master
  import gba_bus_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      cfg_src,
  input  logic [31:0]      cfg_dst,
  input  logic [CNT_W-1:0] cfg_cnt,
  input  logic             cfg_half,
  input  logic [1:0]       cfg_src_mode,
  input  logic [1:0]       cfg_dst_mode,
  output logic [31:0]      addr,
  output logic [31:0]      wdata,
  output logic [1:0]       size,
  output logic             write,
  input  logic [31:0]      rdata,
  input  logic             pause,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  dma_state_t       state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             half_q, half_d;
  logic [1:0]       src_mode_q, src_mode_d;
  logic [1:0]       dst_mode_q, dst_mode_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       size_q, size_d;
  logic             write_q, write_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [31:0]      src_next;
  logic [31:0]      dst_next;
  logic [31:0]      src_start;
  logic [31:0]      dst_start;
  logic [15:0]      rd_half;

  dma_addr_step u_src_step (
    .addr_i (src_q),
    .mode_i (src_mode_q),
    .half_i (half_q),
    .addr_o (src_next)
  );

  dma_addr_step u_dst_step (
    .addr_i (dst_q),
    .mode_i (dst_mode_q),
    .half_i (half_q),
    .addr_o (dst_next)
  );

  assign src_start = dma_align(cfg_src, cfg_half);
  assign dst_start = dma_align(cfg_dst, cfg_half);

  // The lane is chosen by the address of the read that produced rdata; src_q
  // only steps when leaving WRITE, so it still names that read here.
  assign rd_half = src_q[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    half_d     = half_q;
    src_mode_d = src_mode_q;
    dst_mode_d = dst_mode_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    write_d    = write_q;
    busy_d     = busy_q;
    // Pulses hold too while paused; they are cleared only on a live cycle.
    done_d     = done_q;
    err_d      = err_q;

    if (!pause) begin
      done_d = 1'b0;
      err_d  = 1'b0;

      case (state_q)
        DMA_IDLE: begin
          if (start) begin
            state_d    = DMA_READ;
            src_d      = src_start;
            dst_d      = dst_start;
            cnt_d      = cfg_cnt;
            half_d     = cfg_half;
            src_mode_d = cfg_src_mode;
            dst_mode_d = cfg_dst_mode;
            size_d     = cfg_half ? MEM_SIZE_HALF : MEM_SIZE_WORD;
            addr_d     = src_start;
            write_d    = 1'b0;
            busy_d     = 1'b1;
          end
        end

        DMA_READ: begin
          state_d = DMA_WRITE;
          addr_d  = dst_q;
          write_d = 1'b1;
        end

        DMA_WRITE: begin
          // Read data of the preceding READ is on rdata now; it becomes the
          // write data presented during the next cycle.
          wdata_d = half_q ? {rd_half, rd_half} : rdata;
          src_d   = src_next;
          dst_d   = dst_next;
          cnt_d   = cnt_q - CNT_ONE;
          write_d = 1'b0;
          // A count of zero wraps through all ones, giving 2^CNT_W units.
          if (cnt_q != CNT_ONE) begin
            state_d = DMA_READ;
            addr_d  = src_next;
          end else begin
            state_d = DMA_DRAIN;
          end
        end

        DMA_DRAIN: begin
          state_d = DMA_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end

        default: begin
          state_d = DMA_IDLE;
          write_d = 1'b0;
          busy_d  = 1'b0;
        end
      endcase

      // Responder error ends the block at once and discards what is left.
      if (abort && (state_q != DMA_IDLE)) begin
        state_d = DMA_IDLE;
        write_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DMA_IDLE;
      src_q      <= 32'd0;
      dst_q      <= 32'd0;
      cnt_q      <= '0;
      half_q     <= 1'b0;
      src_mode_q <= 2'd0;
      dst_mode_q <= 2'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      size_q     <= MEM_SIZE_WORD;
      write_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      src_mode_q <= src_mode_d;
      dst_mode_q <= dst_mode_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      write_q    <= write_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign addr  = addr_q;
  assign wdata = wdata_q;
  assign size  = size_q;
  assign write = write_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_dma_bus_master.sv
// tb/tb_dma_bus_master.sv - scoreboard bench for dma_bus_master
`timescale 1ns/1ps
module tb_dma_bus_master;
  import gba_bus_pkg::*;

  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [31:0]      cfg_src;
  logic [31:0]      cfg_dst;
  logic [CNT_W-1:0] cfg_cnt;
  logic             cfg_half;
  logic [1:0]       cfg_src_mode;
  logic [1:0]       cfg_dst_mode;
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic [1:0]       size;
  logic             write;
  logic [31:0]      rdata;
  logic             pause;
  logic             abort;
  logic             busy;
  logic             done;
  logic             err;

  always #5 clk = ~clk;

  dma_bus_master #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_cnt(cfg_cnt), .cfg_half(cfg_half),
    .cfg_src_mode(cfg_src_mode), .cfg_dst_mode(cfg_dst_mode),
    .addr(addr), .wdata(wdata), .size(size), .write(write), .rdata(rdata),
    .pause(pause), .abort(abort), .busy(busy), .done(done), .err(err)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  s;
  } wr_t;

  typedef struct packed {
    logic        is_err;
    logic [31:0] cyc;
    logic [31:0] busy_n;
  } ev_t;

  wr_t exp_wr[$];
  ev_t exp_ev[$];

  logic [31:0] srcmem [int unsigned];
  logic [31:0] dstmem [int unsigned];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] src_rd(input logic [31:0] a);
    int unsigned k;
    k = {2'b00, a[31:2]};
    if (srcmem.exists(k)) return srcmem[k];
    return 32'hBAD0_BAD0;
  endfunction

  function automatic logic [31:0] dst_rd(input logic [31:0] a);
    int unsigned k;
    k = {2'b00, a[31:2]};
    if (dstmem.exists(k)) return dstmem[k];
    return 32'h0;
  endfunction

  task automatic src_wr(input logic [31:0] a, input logic [31:0] d);
    int unsigned k;
    k = {2'b00, a[31:2]};
    srcmem[k] = d;
  endtask

  task automatic exp_w(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    wr_t e;
    e.a = a; e.d = d; e.s = s;
    exp_wr.push_back(e);
  endtask

  task automatic exp_e(input logic is_err, input int c, input int bn);
    ev_t e;
    e.is_err = is_err; e.cyc = c; e.busy_n = bn;
    exp_ev.push_back(e);
  endtask

  // Responder read side: data for a read address phase appears next cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) rdata <= 32'd0;
    else if (!pause && busy && !write) rdata <= src_rd(addr);
  end

  // Monitor: write data phases and done/err events against the scoreboard.
  logic        pend = 1'b0;
  logic [31:0] pend_a = 32'd0;
  int          busy_n = 0;
  wr_t         mon_w;
  ev_t         mon_e;
  logic [31:0] mon_old;
  int unsigned mon_k;

  always @(negedge clk) begin
    if (rst) begin
      pend   = 1'b0;
      busy_n = 0;
    end else begin
      if (!pause) begin
        if (pend) begin
          if (exp_wr.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wr_unexpected: got addr %h data %h expected no write", pend_a, wdata);
          end else begin
            mon_w = exp_wr.pop_front();
            chk("wr_addr", 64'(pend_a), 64'(mon_w.a));
            chk("wr_data", 64'(wdata), 64'(mon_w.d));
            chk("wr_size", 64'(size), 64'(mon_w.s));
          end
          mon_k   = {2'b00, pend_a[31:2]};
          mon_old = dstmem.exists(mon_k) ? dstmem[mon_k] : 32'h0;
          if (size == MEM_SIZE_HALF)
            mon_old = pend_a[1] ? {wdata[31:16], mon_old[15:0]} : {mon_old[31:16], wdata[15:0]};
          else
            mon_old = wdata;
          dstmem[mon_k] = mon_old;
        end
        pend   = write;
        pend_a = addr;
      end
      if (busy) busy_n++;
      if (!pause && (done || err)) begin
        if (exp_ev.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL ev_unexpected: got done=%0b err=%0b expected none", done, err);
        end else begin
          mon_e = exp_ev.pop_front();
          chk("ev_kind_err", 64'(err), 64'(mon_e.is_err));
          chk("ev_kind_done", 64'(done), 64'(!mon_e.is_err));
          chk("ev_cycle", 64'(cyc), 64'(mon_e.cyc));
          chk("ev_busy_cycles", 64'(busy_n), 64'(mon_e.busy_n));
          chk("ev_busy_low", 64'(busy), 64'd0);
          chk("ev_write_low", 64'(write), 64'd0);
        end
        busy_n = 0;
      end
    end
  end

  task automatic go(input logic [31:0] s, input logic [31:0] d, input logic [CNT_W-1:0] n,
                    input logic h, input logic [1:0] sm, input logic [1:0] dm, output int c0);
    @(posedge clk); #1;
    cfg_src = s; cfg_dst = d; cfg_cnt = n; cfg_half = h;
    cfg_src_mode = sm; cfg_dst_mode = dm;
    start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic settle(input string name, input int budget);
    int i = 0;
    while ((exp_ev.size() != 0 || exp_wr.size() != 0) && i < budget) begin
      @(posedge clk);
      i++;
    end
    chk({name, "_drained"}, 64'(exp_ev.size() + exp_wr.size()), 64'd0);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog");
  end

  int c0;

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
    cfg_src = 32'd0; cfg_dst = 32'd0; cfg_cnt = '0; cfg_half = 1'b0;
    cfg_src_mode = 2'd0; cfg_dst_mode = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_addr", 64'(addr), 64'd0);
    chk("reset_wdata", 64'(wdata), 64'd0);
    chk("reset_ctrl", 64'({size, write, busy, done, err}), 64'({MEM_SIZE_WORD, 4'b0000}));
    @(posedge clk); #1;
    rst = 1'b0;

    // Word copy, INC/INC, 4 units
    src_wr(32'h0300_0000, 32'h1234_5678);
    src_wr(32'h0300_0004, 32'h9ABC_DEF0);
    src_wr(32'h0300_0008, 32'h0F1E_2D3C);
    src_wr(32'h0300_000C, 32'hA5A5_5A5A);
    exp_w(32'h0200_0000, 32'h1234_5678, MEM_SIZE_WORD);
    exp_w(32'h0200_0004, 32'h9ABC_DEF0, MEM_SIZE_WORD);
    exp_w(32'h0200_0008, 32'h0F1E_2D3C, MEM_SIZE_WORD);
    exp_w(32'h0200_000C, 32'hA5A5_5A5A, MEM_SIZE_WORD);
    go(32'h0300_0000, 32'h0200_0000, 3'd4, 1'b0, 2'd0, 2'd0, c0);
    exp_e(1'b0, c0 + 10, 9);
    settle("word_copy", 40);

    // Halfword copy from an odd-halfword source
    src_wr(32'h0300_0000, 32'h1111_DEAD);
    src_wr(32'h0300_0004, 32'h3333_2222);
    exp_w(32'h0600_0000, 32'h1111_1111, MEM_SIZE_HALF);
    exp_w(32'h0600_0002, 32'h2222_2222, MEM_SIZE_HALF);
    exp_w(32'h0600_0004, 32'h3333_3333, MEM_SIZE_HALF);
    go(32'h0300_0002, 32'h0600_0000, 3'd3, 1'b1, 2'd0, 2'd0, c0);
    exp_e(1'b0, c0 + 8, 7);
    settle("half_copy", 40);
    chk("half_mem0", 64'(dst_rd(32'h0600_0000)), 64'h2222_1111);
    chk("half_mem1", 64'(dst_rd(32'h0600_0004)), 64'h0000_3333);

    // Source mode 3 (FIXED), destination DEC from an unaligned start
    src_wr(32'h0400_0000, 32'h4444_0001);
    src_wr(32'h0400_0004, 32'h5555_0002);
    src_wr(32'h03FF_FFFC, 32'h6666_0003);
    exp_w(32'h0200_0010, 32'h4444_0001, MEM_SIZE_WORD);
    exp_w(32'h0200_000C, 32'h4444_0001, MEM_SIZE_WORD);
    exp_w(32'h0200_0008, 32'h4444_0001, MEM_SIZE_WORD);
    go(32'h0400_0000, 32'h0200_0013, 3'd3, 1'b0, 2'd3, 2'd1, c0);
    exp_e(1'b0, c0 + 8, 7);
    settle("modes", 40);

    // Pause for 3 cycles during the second WRITE
    src_wr(32'h0300_0100, 32'hCAFE_0100);
    src_wr(32'h0300_0104, 32'hCAFE_0104);
    exp_w(32'h0200_0100, 32'hCAFE_0100, MEM_SIZE_WORD);
    exp_w(32'h0200_0104, 32'hCAFE_0104, MEM_SIZE_WORD);
    go(32'h0300_0100, 32'h0200_0100, 3'd2, 1'b0, 2'd0, 2'd0, c0);
    exp_e(1'b0, c0 + 9, 8);
    repeat (3) @(posedge clk);
    #1 pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("pause_addr", 64'(addr), 64'h0200_0104);
      chk("pause_write", 64'({write, busy}), 64'b11);
      chk("pause_wdata", 64'(wdata), 64'hCAFE_0100);
      @(posedge clk); #1;
    end
    pause = 1'b0;
    settle("pause", 40);
    chk("pause_mem0", 64'(dst_rd(32'h0200_0100)), 64'hCAFE_0100);
    chk("pause_mem1", 64'(dst_rd(32'h0200_0104)), 64'hCAFE_0104);

    // Abort in the cycle after the first WRITE
    src_wr(32'h0300_0200, 32'hAB00_0000);
    src_wr(32'h0300_0204, 32'hAB00_0004);
    src_wr(32'h0300_0208, 32'hAB00_0008);
    src_wr(32'h0300_020C, 32'hAB00_000C);
    exp_w(32'h0200_0200, 32'hAB00_0000, MEM_SIZE_WORD);
    go(32'h0300_0200, 32'h0200_0200, 3'd4, 1'b0, 2'd0, 2'd0, c0);
    exp_e(1'b1, c0 + 4, 3);
    @(posedge clk); #1;
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    settle("abort", 40);
    repeat (10) @(posedge clk);
    chk("abort_mem0", 64'(dst_rd(32'h0200_0200)), 64'hAB00_0000);
    chk("abort_mem1", 64'(dst_rd(32'h0200_0204)), 64'h0);
    chk("abort_busy", 64'(busy), 64'd0);

    // Reset mid-transfer, then a fresh transfer
    go(32'h0300_0200, 32'h0200_0300, 3'd4, 1'b0, 2'd0, 2'd0, c0);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("rst_mid_addr", 64'(addr), 64'd0);
    chk("rst_mid_wdata", 64'(wdata), 64'd0);
    chk("rst_mid_ctrl", 64'({size, write, busy, done, err}), 64'({MEM_SIZE_WORD, 4'b0000}));
    @(posedge clk); #1 rst = 1'b0;
    src_wr(32'h0300_0400, 32'h7777_0400);
    src_wr(32'h0300_0404, 32'h7777_0404);
    exp_w(32'h0200_0400, 32'h7777_0400, MEM_SIZE_WORD);
    exp_w(32'h0200_0404, 32'h7777_0404, MEM_SIZE_WORD);
    go(32'h0300_0400, 32'h0200_0400, 3'd2, 1'b0, 2'd0, 2'd0, c0);
    exp_e(1'b0, c0 + 6, 5);
    settle("after_reset", 40);
    chk("rst_mid_nowrite", 64'(dst_rd(32'h0200_0300)), 64'h0);

    // Count 0 = 2^CNT_W units, destination wraps past 0xFFFF_FFFC
    for (int i = 0; i < 8; i++) begin
      src_wr(32'h0300_0300 + 32'(4 * i), 32'hF00D_0000 + 32'(i));
      exp_w(32'hFFFF_FFF8 + 32'(4 * i), 32'hF00D_0000 + 32'(i), MEM_SIZE_WORD);
    end
    go(32'h0300_0300, 32'hFFFF_FFF8, 3'd0, 1'b0, 2'd0, 2'd0, c0);
    exp_e(1'b0, c0 + 18, 17);
    settle("cnt_zero_wrap", 60);
    chk("wrap_mem_zero", 64'(dst_rd(32'h0000_0000)), 64'hF00D_0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
